// File: rtl/branch_target_table_if.sv
// Lookup and streaming-load signal bundle for the branch target table.
`timescale 1ns/1ps
interface branch_target_table_if #(
    parameter int unsigned D  = 10,
    parameter int unsigned AW = 4
);
    logic          lookup_en;
    logic [AW-1:0] addr;
    logic [D-1:0]  pc;
    logic [D-1:0]  target;
    logic          target_valid;
    logic          hit;
    logic          load_start;
    logic          load_valid;
    logic          load_ready;
    logic [D-1:0]  load_data;
    logic          load_rel;
    logic          load_done;
    logic          busy;
    logic          flush;

    modport master (
        output lookup_en, addr, pc, load_start, load_valid, load_data, load_rel, flush,
        input  target, target_valid, hit, load_ready, load_done, busy
    );

    modport slave (
        input  lookup_en, addr, pc, load_start, load_valid, load_data, load_rel, flush,
        output target, target_valid, hit, load_ready, load_done, busy
    );
endinterface

// File: rtl/branch_target_table.sv
// Runtime-loadable branch target table: registered lookup with absolute or
// PC-relative entries, filled sequentially over a valid/ready stream.
`timescale 1ns/1ps
module branch_target_table #(
    parameter int unsigned D      = 10,
    parameter int unsigned AW     = 4,
    parameter bit          REL_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_target_table_if.slave bus
);
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t        state_q;
    logic [AW-1:0] ptr_q;
    logic          ready_q;
    logic          done_q;
    logic          busy_q;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] rel_q;
    logic [D-1:0]     data_q [DEPTH];

    logic [D-1:0] target_q;
    logic [D-1:0] target_d;
    logic         hit_q;
    logic         tv_q;
    logic         beat_c;

    assign beat_c = bus.load_valid & ready_q;

    // Entry resolution reads pre-edge contents, giving read-before-write.
    always_comb begin
        target_d = '0;
        if (valid_q[bus.addr]) begin
            if (rel_q[bus.addr]) target_d = data_q[bus.addr] + bus.pc;
            else                 target_d = data_q[bus.addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_q <= '0;
            hit_q    <= 1'b0;
            tv_q     <= 1'b0;
        end else begin
            tv_q <= bus.lookup_en;
            if (bus.lookup_en) begin
                target_q <= target_d;
                hit_q    <= valid_q[bus.addr];
            end
        end
    end

    // Table storage; flush only invalidates, payload bits are don't-care once invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            rel_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= '0;
        end else if (bus.flush) begin
            valid_q <= '0;
        end else if (beat_c) begin
            valid_q[ptr_q] <= 1'b1;
            rel_q[ptr_q]   <= bus.load_rel & REL_EN;
            data_q[ptr_q]  <= bus.load_data;
        end
    end

    // Load sequencer with registered handshake/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (bus.flush) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.load_start) begin
                        state_q <= LOAD;
                        ptr_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (beat_c) begin
                        ptr_q <= ptr_q + AW'(1);
                        if (ptr_q == AW'(DEPTH - 1)) begin
                            state_q <= DONE;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ptr_q   <= '0;
                    ready_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.target       = target_q;
    assign bus.hit          = hit_q;
    assign bus.target_valid = tv_q;
    assign bus.load_ready   = ready_q;
    assign bus.load_done    = done_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_branch_target_table.sv
// Directed/randomised bench for branch_target_table; a REL_EN=1 and a REL_EN=0
// instance share one stimulus stream and are checked against an array model.
`timescale 1ns/1ps
module tb_branch_target_table;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    branch_target_table_if #(.D(10), .AW(4)) b0 ();
    branch_target_table_if #(.D(10), .AW(4)) b1 ();

    assign b1.lookup_en  = b0.lookup_en;
    assign b1.addr       = b0.addr;
    assign b1.pc         = b0.pc;
    assign b1.load_start = b0.load_start;
    assign b1.load_valid = b0.load_valid;
    assign b1.load_data  = b0.load_data;
    assign b1.load_rel   = b0.load_rel;
    assign b1.flush      = b0.flush;

    branch_target_table #(.D(10), .AW(4), .REL_EN(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    branch_target_table #(.D(10), .AW(4), .REL_EN(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    int errors = 0;
    int checks = 0;
    int done_seen = 0;

    // Reference model: table contents plus load phase (0 idle, 1 loading, 2 finishing).
    bit m_valid [16];
    bit m_rel   [16];
    int m_data  [16];
    int m_phase;
    int m_ptr;
    int exp_t0, exp_t1, exp_hit, exp_tv;
    int pd [16];
    bit pr [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int f_target(input int idx, input int pcv, input bit use_rel);
        if (!m_valid[idx]) return 0;
        if (use_rel && m_rel[idx]) return (pcv + m_data[idx]) % 1024;
        return m_data[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_rel[i] = 0; m_data[i] = 0;
        end
        m_phase = 0; m_ptr = 0;
        exp_t0 = 0; exp_t1 = 0; exp_hit = 0; exp_tv = 0;
    endtask

    task automatic model_edge();
        if (b0.lookup_en) begin
            exp_hit = int'(m_valid[b0.addr]);
            exp_t0  = f_target(int'(b0.addr), int'(b0.pc), 1'b1);
            exp_t1  = f_target(int'(b0.addr), int'(b0.pc), 1'b0);
        end
        exp_tv = int'(b0.lookup_en);
        if (b0.flush) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 0;
            m_phase = 0; m_ptr = 0;
        end else if (m_phase == 0) begin
            if (b0.load_start) begin m_phase = 1; m_ptr = 0; end
        end else if (m_phase == 1) begin
            if (b0.load_valid) begin
                m_valid[m_ptr] = 1;
                m_rel[m_ptr]   = b0.load_rel;
                m_data[m_ptr]  = int'(b0.load_data);
                if (m_ptr == 15) m_phase = 2;
                m_ptr = (m_ptr + 1) % 16;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic check_all();
        if (b0.load_done === 1'b1) done_seen++;
        chk("target_valid", 32'(b0.target_valid), exp_tv);
        chk("target", 32'(b0.target), exp_t0);
        chk("hit", 32'(b0.hit), exp_hit);
        chk("target_norel", 32'(b1.target), exp_t1);
        chk("hit_norel", 32'(b1.hit), exp_hit);
        chk("load_ready", 32'(b0.load_ready), 32'(m_phase == 1));
        chk("load_done", 32'(b0.load_done), 32'(m_phase == 2));
        chk("busy", 32'(b0.busy), 32'(m_phase != 0));
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic drive_idle();
        b0.lookup_en = 0; b0.addr = '0; b0.pc = '0;
        b0.load_start = 0; b0.load_valid = 0; b0.load_data = '0; b0.load_rel = 0;
        b0.flush = 0;
    endtask

    task automatic lookup(input int idx, input int pcv);
        drive_idle();
        b0.lookup_en = 1; b0.addr = 4'(idx); b0.pc = 10'(pcv);
        cyc();
        drive_idle();
    endtask

    task automatic fill(input bit allow_rel);
        for (int i = 0; i < 16; i++) begin
            pd[i] = int'($urandom_range(0, 1023));
            pr[i] = allow_rel ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        pd[15] = pd[15] | 1;
    endtask

    // Start a load and stream beats until max_beats offered or the load ends.
    task automatic do_load(input bit gaps, input int max_beats, input int rw_idx);
        int n = 0;
        int guard = 0;
        bit rw;
        int old_t, rw_pc;
        drive_idle();
        b0.load_start = 1;
        cyc();
        drive_idle();
        while (m_phase == 1 && n < max_beats && guard < 400) begin
            guard++;
            b0.load_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            b0.load_data  = 10'(pd[m_ptr]);
            b0.load_rel   = pr[m_ptr];
            b0.lookup_en  = ($urandom_range(0, 3) == 0);
            b0.addr       = 4'($urandom_range(0, 15));
            b0.pc         = 10'($urandom);
            rw = 0;
            if (m_ptr == rw_idx && b0.load_valid) begin
                rw = 1;
                b0.lookup_en = 1; b0.addr = 4'(rw_idx);
                rw_pc = int'(b0.pc);
                old_t = f_target(rw_idx, rw_pc, 1'b1);
            end
            if (b0.load_valid) n++;
            cyc();
            if (rw) begin
                chk("rw_old", 32'(b0.target), old_t);
                drive_idle();
                b0.lookup_en = 1; b0.addr = 4'(rw_idx); b0.pc = 10'(rw_pc);
                cyc();
                chk("rw_new", 32'(b0.target),
                    pr[rw_idx] ? (rw_pc + pd[rw_idx]) % 1024 : pd[rw_idx]);
            end
        end
        if (guard >= 400) begin
            checks++; errors++;
            $error("FAIL load_timeout observed=%0d expected=%0d", n, max_beats);
        end
        drive_idle();
    endtask

    initial begin
        int d0;
        drive_idle();
        model_reset();
        reset = 1;
        @(negedge clk); @(negedge clk);
        check_all();
        reset = 0;

        // 1: lookup after reset misses, target_valid pulses once.
        lookup(3, 0);
        chk("t1_hit", 32'(b0.hit), 0);
        chk("t1_tv", 32'(b0.target_valid), 1);
        cyc();
        chk("t1_tv_drop", 32'(b0.target_valid), 0);

        // 2: absolute load, single done pulse.
        fill(1'b0);
        pd[2] = 80; pd[4] = 119;
        d0 = done_seen;
        do_load(1'b0, 16, -1);
        cyc();
        chk("t2_done_once", 32'(done_seen - d0), 1);
        cyc();
        chk("t2_busy_low", 32'(b0.busy), 0);
        lookup(2, 0);
        chk("t2_e2", 32'(b0.target), 80);
        chk("t2_e2_hit", 32'(b0.hit), 1);
        lookup(4, 0);
        chk("t2_e4", 32'(b0.target), 119);

        // 3: relative entries and wrap-around.
        fill(1'b1);
        pd[9] = 'h3FB; pr[9] = 1;
        pd[1] = 20;    pr[1] = 1;
        do_load(1'b0, 16, -1);
        cyc(); cyc();
        lookup(9, 4);
        chk("t3_e9_rel", 32'(b0.target), 'h3FF);
        chk("t3_e9_abs", 32'(b1.target), 'h3FB);
        lookup(1, 1020);
        chk("t3_e1_rel", 32'(b0.target), 16);

        // 4: gapped load with same-cycle write/lookup of index 7.
        fill(1'b1);
        do_load(1'b1, 16, 7);
        cyc(); cyc();
        for (int i = 0; i < 16; i++) lookup(i, int'($urandom_range(0, 1023)));

        // 5: flush mid-load with colliding beat, start and lookup.
        fill(1'b1);
        d0 = done_seen;
        do_load(1'b0, 5, -1);
        b0.flush = 1; b0.load_valid = 1; b0.load_start = 1;
        b0.load_data = 10'h155; b0.lookup_en = 1; b0.addr = 4'd0; b0.pc = '0;
        cyc();
        drive_idle();
        chk("t5_preflush_hit", 32'(b0.hit), 1);
        chk("t5_busy", 32'(b0.busy), 0);
        for (int i = 0; i < 16; i++) begin
            lookup(i, 0);
            chk("t5_flushed_hit", 32'(b0.hit), 0);
        end
        chk("t5_no_done", 32'(done_seen - d0), 0);
        fill(1'b1);
        do_load(1'b1, 16, -1);
        cyc(); cyc();
        for (int i = 0; i < 16; i++) lookup(i, int'($urandom_range(0, 1023)));

        // 6: asynchronous reset between edges during a load.
        lookup(15, 0);
        fill(1'b1);
        do_load(1'b0, 4, -1);
        model_edge();
        @(posedge clk);
        #2 reset = 1;
        #1;
        chk("t6_ready", 32'(b0.load_ready), 0);
        chk("t6_busy", 32'(b0.busy), 0);
        chk("t6_target", 32'(b0.target), 0);
        chk("t6_tv", 32'(b0.target_valid), 0);
        model_reset();
        @(negedge clk);
        check_all();
        reset = 0;
        lookup(0, 0);
        chk("t6_post_hit", 32'(b0.hit), 0);
        fill(1'b1);
        do_load(1'b0, 16, -1);
        cyc(); cyc();
        for (int i = 0; i < 16; i++) lookup(i, int'($urandom_range(0, 1023)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
